// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: pipeline request/response handshake,
// data-memory port, and the out-of-range fault pulse.
// slave  = the access unit itself; master = pipeline plus memory side.
interface mem_access_unit_if #(
  parameter int TAG_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [15:0]      req_addr;
  logic [15:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic [15:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_wd;
  logic             mem_we;
  logic [15:0]      mem_rd;
  logic             fault;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_tag, mem_rd,
    output req_ready, resp_valid, resp_data, resp_tag,
           mem_addr, mem_wd, mem_we, fault
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_tag, mem_rd,
    input  req_ready, resp_valid, resp_data, resp_tag,
           mem_addr, mem_wd, mem_we, fault
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage initiator for a 16-bit word-addressed data
// memory with one-cycle synchronous read latency. One request in flight.
// States: IDLE -> ISSUE -> (store) IDLE | (load) WAIT -> RESP.
// Optional feature: define MEM_ACCESS_BOUNDS_CHECK_EN to flag accesses with
// address >= DEPTH (fault pulse in ISSUE, store dropped, load returns 0).
module mem_access_unit #(
  parameter int DEPTH = 256,
  parameter int TAG_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic [15:0]      addr_reg, wd_reg, resp_data_reg;
  logic             we_reg, is_store_reg, oob_reg;
  logic [TAG_W-1:0] tag_reg, resp_tag_reg;
  logic             ready;
  logic             accept;
  logic             req_oob;

  // Out-of-range detection on the incoming address; constant 0 when disabled.
  assign req_oob = BOUNDS_EN && ({1'b0, bus.req_addr} >= DEPTH_L);
  assign accept  = bus.req_valid && ready;

  // Next-state and ready decode; accepting in RESP chains straight into ISSUE.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) state_next = ISSUE;
      end
      ISSUE:   state_next = is_store_reg ? IDLE : WAIT;
      WAIT:    state_next = RESP;
      RESP: begin
        ready      = 1'b1;
        state_next = bus.req_valid ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Request latch, memory port drive, and load data capture at the end of WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      wd_reg        <= '0;
      we_reg        <= 1'b0;
      is_store_reg  <= 1'b0;
      oob_reg       <= 1'b0;
      tag_reg       <= '0;
      resp_data_reg <= '0;
      resp_tag_reg  <= '0;
    end else begin
      // ISSUE always lasts exactly one cycle, so the write strobe self-clears.
      we_reg <= 1'b0;
      if (accept) begin
        addr_reg     <= bus.req_addr;
        wd_reg       <= bus.req_wdata;
        we_reg       <= bus.req_we && !req_oob;
        is_store_reg <= bus.req_we;
        oob_reg      <= req_oob;
        tag_reg      <= bus.req_tag;
      end
      if (state_reg == WAIT) begin
        resp_data_reg <= oob_reg ? 16'h0000 : bus.mem_rd;
        resp_tag_reg  <= tag_reg;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state_reg == RESP);
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_tag   = resp_tag_reg;
  assign bus.mem_addr   = addr_reg;
  assign bus.mem_wd     = wd_reg;
  assign bus.mem_we     = we_reg;
  assign bus.fault      = (state_reg == ISSUE) && oob_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioral
// synchronous-read data memory attached to the memory port.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  mem_access_unit_if #(.TAG_W(3)) bus ();

  mem_access_unit #(.DEPTH(256), .TAG_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Data memory model: write and registered read on the same edge.
  bit [15:0] mem_model [0:511];
  always @(posedge clk) begin
    if (bus.mem_we) mem_model[bus.mem_addr[8:0]] <= bus.mem_wd;
    bus.mem_rd <= mem_model[bus.mem_addr[8:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [15:0] a,
                       input logic [15:0] d, input logic [2:0] t);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_tag   = t;
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    // Reset state
    #12;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_outs_zero", {bus.resp_data, bus.mem_addr} | 32'(bus.mem_wd) | 32'(bus.resp_tag) | 32'(bus.fault), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(bus.req_ready), 32'd1);

    // Store 0x0010 <- 0xBEEF
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 3'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    check("st_issue_we", 32'(bus.mem_we), 32'd1);
    check("st_issue_ready", 32'(bus.req_ready), 32'd0);
    check("st_issue_addr", 32'(bus.mem_addr), 32'h0010);
    tick();
    check("st_done_we", 32'(bus.mem_we), 32'd0);
    check("st_done_ready", 32'(bus.req_ready), 32'd1);
    check("st_mem", 32'(mem_model[9'h010]), 32'hBEEF);
    check("st_no_resp", 32'(bus.resp_valid), 32'd0);

    // Load 0x0010 tag 5
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 3'd5);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    check("ld_issue_we", 32'(bus.mem_we), 32'd0);
    check("ld_issue_rv", 32'(bus.resp_valid), 32'd0);
    tick();
    check("ld_wait_rv", 32'(bus.resp_valid), 32'd0);
    tick();
    check("ld_resp_rv", 32'(bus.resp_valid), 32'd1);
    check("ld_resp_data", 32'(bus.resp_data), 32'hBEEF);
    check("ld_resp_tag", 32'(bus.resp_tag), 32'd5);
    tick();
    check("ld_after_rv", 32'(bus.resp_valid), 32'd0);
    check("ld_hold_data", 32'(bus.resp_data), 32'hBEEF);

    // Preload 0x0001/0x0002 via stores
    drive(1'b1, 1'b1, 16'h0001, 16'h1111, 3'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 16'h0002, 16'h2222, 3'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    tick();
    check("pre_mem2", 32'(mem_model[9'h002]), 32'h2222);

    // Back-to-back loads, req_valid held
    drive(1'b1, 1'b0, 16'h0001, 16'h0, 3'd1);
    tick();
    drive(1'b1, 1'b0, 16'h0002, 16'h0, 3'd2);
    check("b2b_issue_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("b2b_wait_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("b2b_r1_rv", 32'(bus.resp_valid), 32'd1);
    check("b2b_r1_ready", 32'(bus.req_ready), 32'd1);
    check("b2b_r1_data", 32'(bus.resp_data), 32'h1111);
    check("b2b_r1_tag", 32'(bus.resp_tag), 32'd1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    check("b2b_accept_addr", 32'(bus.mem_addr), 32'h0002);
    check("b2b_gap_rv", 32'(bus.resp_valid), 32'd0);
    tick();
    check("b2b_gap2_rv", 32'(bus.resp_valid), 32'd0);
    tick();
    check("b2b_r2_rv", 32'(bus.resp_valid), 32'd1);
    check("b2b_r2_data", 32'(bus.resp_data), 32'h2222);
    check("b2b_r2_tag", 32'(bus.resp_tag), 32'd2);
    tick();

    // Reset asserted during ISSUE of store 0x0020 <- 0xAAAA
    drive(1'b1, 1'b1, 16'h0020, 16'hAAAA, 3'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    check("rsti_issue_we", 32'(bus.mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rsti_async_we", 32'(bus.mem_we), 32'd0);
    check("rsti_async_addr", 32'(bus.mem_addr), 32'd0);
    check("rsti_async_ready", 32'(bus.req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rsti_no_resp", 32'(bus.resp_valid), 32'd0);
      check("rsti_no_we", 32'(bus.mem_we), 32'd0);
    end
    check("rsti_mem", 32'(mem_model[9'h020]), 32'h0000);

    // Address 0x0100: out of range when the bounds check is built in
    drive(1'b1, 1'b1, 16'h0100, 16'h1234, 3'd0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    check("oob_st_fault", 32'(bus.fault), 32'(BC));
    check("oob_st_we", 32'(bus.mem_we), 32'(!BC));
    tick();
    check("oob_st_fault_end", 32'(bus.fault), 32'd0);
    check("oob_st_mem", 32'(mem_model[9'h100]), BC ? 32'h0000 : 32'h1234);
    drive(1'b1, 1'b0, 16'h0100, 16'h0, 3'd3);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    check("oob_ld_fault", 32'(bus.fault), 32'(BC));
    tick();
    check("oob_ld_fault_end", 32'(bus.fault), 32'd0);
    tick();
    check("oob_ld_rv", 32'(bus.resp_valid), 32'd1);
    check("oob_ld_data", 32'(bus.resp_data), BC ? 32'h0000 : 32'h1234);
    check("oob_ld_tag", 32'(bus.resp_tag), 32'd3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
